// File: rtl/fft16_pkg.sv
// fft16_pkg
// Shared definitions for the 16-point radix-2 DIF FFT sequencer:
//   DW      sample width (signed Q16.16 per real/imag part)
//   N       FFT length (fixed at 16)
//   LOG2N   log2 of N
//   state_t sequencer states
//   TW_RE / TW_IM  twiddle factors W16^k for k = 0..7, Q16.16
//   bitrev4 4-bit bit reversal used to read the spectrum in natural order
package fft16_pkg;

    localparam int DW    = 32;
    localparam int N     = 16;
    localparam int LOG2N = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_DRAIN,
        ST_UNLOAD
    } state_t;

    // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), scaled by 65536
    localparam logic signed [DW-1:0] TW_RE [8] = '{
        32'sd65536,  32'sd60547,  32'sd46341,  32'sd25080,
        32'sd0,     -32'sd25080, -32'sd46341, -32'sd60547
    };
    localparam logic signed [DW-1:0] TW_IM [8] = '{
        32'sd0,     -32'sd25080, -32'sd46341, -32'sd60547,
       -32'sd65536, -32'sd60547, -32'sd46341, -32'sd25080
    };

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft16_twiddle_rom.sv
// fft16_twiddle_rom
// Combinational twiddle lookup.
//   k     in  3   twiddle index
//   w_re  out DW  real part of W16^k, Q16.16
//   w_im  out DW  imaginary part of W16^k, Q16.16
module fft16_twiddle_rom
    import fft16_pkg::*;
(
    input  logic [2:0]    k,
    output logic [DW-1:0] w_re,
    output logic [DW-1:0] w_im
);

    assign w_re = TW_RE[k];
    assign w_im = TW_IM[k];

endmodule

// File: rtl/fft16_dif_sequencer.sv
// fft16_dif_sequencer
// Buffers 16 complex samples, runs 4 radix-2 DIF butterfly stages (sum kept
// locally, difference*twiddle computed by an external registered multiplier),
// then streams X[0..15] out in natural order.
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        input sample handshake, in_re/in_im sample
//   mul_valid                operand strobe to the multiplier
//   mul_a_*, mul_b_*, mul_w_* operands A = x[i+h], B = x[i], twiddle
//   mul_re/mul_im            multiplier result (B-A)*W, one cycle after mul_valid
//   out_valid/out_ready      spectrum handshake, out_re/out_im sample
//   out_last                 marks X[15]
//   busy                     frame in progress
module fft16_dif_sequencer
    import fft16_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          mul_valid,
    output logic [DW-1:0] mul_a_re,
    output logic [DW-1:0] mul_a_im,
    output logic [DW-1:0] mul_b_re,
    output logic [DW-1:0] mul_b_im,
    output logic [DW-1:0] mul_w_re,
    output logic [DW-1:0] mul_w_im,
    input  logic [DW-1:0] mul_re,
    input  logic [DW-1:0] mul_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          busy
);

    state_t        state, state_nxt;
    logic [3:0]    cnt;       // load index
    logic [1:0]    s;         // stage
    logic [2:0]    bf;        // butterfly within stage
    logic [3:0]    oidx;      // output index (natural order)
    logic          wb_valid;  // multiplier result lands this cycle
    logic [3:0]    wb_addr;   // destination of that result

    logic [DW-1:0] mem_re [N];
    logic [DW-1:0] mem_im [N];

    logic [3:0]    h, j, idx_i, idx_p, oaddr;
    logic [2:0]    k;
    logic [DW-1:0] w_re, w_im;
    logic          load_we, calc_en;

    // Butterfly addressing: h = 8>>s is the span, butterflies are grouped in
    // blocks of 2h, j is the offset inside the block and k = j<<s.
    always_comb begin
        h     = 4'd8 >> s;
        j     = {1'b0, bf} & (h - 4'd1);
        idx_i = (({1'b0, bf} >> (2'd3 - s)) << (3'd4 - {1'b0, s})) | j;
        idx_p = idx_i + h;
        k     = j[2:0] << s;
    end

    fft16_twiddle_rom u_rom (
        .k    (k),
        .w_re (w_re),
        .w_im (w_im)
    );

    assign in_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign load_we  = in_ready && in_valid;
    assign calc_en  = (state == ST_CALC);

    // Operands are forced to zero outside CALC so the multiplier port is quiet
    // and matches the reset values even though buffer contents are arbitrary.
    assign mul_valid = calc_en;
    assign mul_a_re  = calc_en ? mem_re[idx_p] : '0;
    assign mul_a_im  = calc_en ? mem_im[idx_p] : '0;
    assign mul_b_re  = calc_en ? mem_re[idx_i] : '0;
    assign mul_b_im  = calc_en ? mem_im[idx_i] : '0;
    assign mul_w_re  = calc_en ? w_re : '0;
    assign mul_w_im  = calc_en ? w_im : '0;

    // DIF leaves the spectrum in bit-reversed order inside the buffer.
    assign oaddr     = bitrev4(oidx);
    assign out_valid = (state == ST_UNLOAD);
    assign out_re    = out_valid ? mem_re[oaddr] : '0;
    assign out_im    = out_valid ? mem_im[oaddr] : '0;
    assign out_last  = out_valid && (oidx == 4'd15);
    assign busy      = (state != ST_IDLE);

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_LOAD:
                if (in_valid) state_nxt = (cnt == 4'd15) ? ST_CALC : ST_LOAD;
            ST_CALC:
                if (bf == 3'd7) state_nxt = ST_DRAIN;
            ST_DRAIN:
                state_nxt = (s == 2'd3) ? ST_UNLOAD : ST_CALC;
            ST_UNLOAD:
                if (out_ready && (oidx == 4'd15)) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Counters wrap naturally: cnt after beat 16, bf after butterfly 7,
    // s after stage 3 and oidx after X[15] all return to 0 for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            s        <= '0;
            bf       <= '0;
            oidx     <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
        end else begin
            wb_valid <= calc_en;
            wb_addr  <= idx_p;
            if (load_we)                cnt  <= cnt + 4'd1;
            if (calc_en)                bf   <= bf + 3'd1;
            if (state == ST_DRAIN)      s    <= s + 2'd1;
            if (out_valid && out_ready) oidx <= oidx + 4'd1;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; its contents are
    // meaningless until a frame is loaded, so it stays plain storage.
    // Within a stage butterflies touch disjoint indices, so the sum write and
    // the delayed difference writeback never collide.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_re[cnt] <= in_re;
            mem_im[cnt] <= in_im;
        end
        if (calc_en) begin
            mem_re[idx_i] <= mem_re[idx_i] + mem_re[idx_p];
            mem_im[idx_i] <= mem_im[idx_i] + mem_im[idx_p];
        end
        if (wb_valid) begin
            mem_re[wb_addr] <= mul_re;
            mem_im[wb_addr] <= mul_im;
        end
    end

endmodule

// File: tb/tb_fft16_dif_sequencer.sv
// tb_fft16_dif_sequencer
// Self-checking bench: behavioural DIF FFT model, registered Q16.16 multiplier
// model, randomized frames, protocol/latency/backpressure/reset checks.
module tb_fft16_dif_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_re, in_im;
    logic        mul_valid;
    logic [31:0] mul_a_re, mul_a_im, mul_b_re, mul_b_im, mul_w_re, mul_w_im;
    logic [31:0] mul_re, mul_im;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] out_re, out_im;

    always #5 clk = ~clk;

    fft16_dif_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .mul_valid (mul_valid),
        .mul_a_re  (mul_a_re),
        .mul_a_im  (mul_a_im),
        .mul_b_re  (mul_b_re),
        .mul_b_im  (mul_b_im),
        .mul_w_re  (mul_w_re),
        .mul_w_im  (mul_w_im),
        .mul_re    (mul_re),
        .mul_im    (mul_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int tw_re [8] = '{65536, 60547, 46341, 25080, 0, -25080, -46341, -60547};
    int tw_im [8] = '{0, -25080, -46341, -60547, -65536, -60547, -46341, -25080};

    int x_re [16], x_im [16];
    int exp_re [16], exp_im [16];
    int got_re [16], got_im [16];

    bit          frame_armed     = 1'b0;
    int          acc_idx         = 0;
    int          frames_done     = 0;
    bit          check_idle_next = 1'b0;
    bit          prev_stall      = 1'b0;
    logic [31:0] prev_re, prev_im;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    task automatic check_tol(input string name, input longint got,
                             input longint expv, input longint tol);
        n_checks++;
        if (got - expv <= tol && expv - got <= tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, got, expv, tol);
    endtask

    // Q16.16 complex multiply with floor rounding (the external multiplier).
    function automatic void cmul(input int dr, input int di, input int wr,
                                 input int wi, output int pr, output int pi);
        longint tr, ti;
        tr = longint'(dr) * longint'(wr) - longint'(di) * longint'(wi);
        ti = longint'(dr) * longint'(wi) + longint'(di) * longint'(wr);
        pr = int'(tr >>> 16);
        pi = int'(ti >>> 16);
    endfunction

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < 4; b++) if (v[b]) r |= (1 << (3 - b));
        return r;
    endfunction

    // Textbook in-place DIF FFT over plain integer arrays.
    function automatic void compute_model();
        int a_re [16], a_im [16];
        int tr, ti, ur, ui, pr, pi, h;
        for (int n = 0; n < 16; n++) begin a_re[n] = x_re[n]; a_im[n] = x_im[n]; end
        for (int st = 0; st < 4; st++) begin
            h = 8 >> st;
            for (int base = 0; base < 16; base += 2 * h)
                for (int jj = 0; jj < h; jj++) begin
                    tr = a_re[base + jj];     ti = a_im[base + jj];
                    ur = a_re[base + jj + h]; ui = a_im[base + jj + h];
                    a_re[base + jj] = tr + ur;
                    a_im[base + jj] = ti + ui;
                    cmul(tr - ur, ti - ui, tw_re[jj * (1 << st)], tw_im[jj * (1 << st)], pr, pi);
                    a_re[base + jj + h] = pr;
                    a_im[base + jj + h] = pi;
                end
        end
        for (int kk = 0; kk < 16; kk++) begin
            exp_re[kk] = a_re[brev(kk)];
            exp_im[kk] = a_im[brev(kk)];
        end
    endfunction

    // Registered multiplier: result valid the cycle after operands.
    initial begin
        int pr, pi;
        mul_re = '0;
        mul_im = '0;
        forever begin
            @(posedge clk);
            cmul(int'(mul_b_re) - int'(mul_a_re), int'(mul_b_im) - int'(mul_a_im),
                 int'(mul_w_re), int'(mul_w_im), pr, pi);
            mul_re <= pr;
            mul_im <= pi;
        end
    end

    // Output compare process.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall      = 1'b0;
                check_idle_next = 1'b0;
            end else begin
                if (check_idle_next) begin
                    check("in_ready_after_last", in_ready, 1);
                    check("busy_after_last", busy, 0);
                    check("out_valid_after_last", out_valid, 0);
                    check_idle_next = 1'b0;
                end
                if (prev_stall) begin
                    check("stall_valid_held", out_valid, 1);
                    check("stall_re_stable", out_re, prev_re);
                    check("stall_im_stable", out_im, prev_im);
                end
                if (!out_valid) begin
                    prev_stall = 1'b0;
                    check("out_last_idle", out_last, 0);
                end else if (!frame_armed) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    check($sformatf("X%0d_re", acc_idx), $signed(out_re), exp_re[acc_idx]);
                    check($sformatf("X%0d_im", acc_idx), $signed(out_im), exp_im[acc_idx]);
                    check($sformatf("X%0d_last", acc_idx), out_last, acc_idx == 15);
                    got_re[acc_idx] = int'(out_re);
                    got_im[acc_idx] = int'(out_im);
                    if (out_ready) begin
                        prev_stall = 1'b0;
                        if (acc_idx == 15) begin
                            acc_idx         = 0;
                            frame_armed     = 1'b0;
                            frames_done++;
                            check_idle_next = 1'b1;
                        end else acc_idx++;
                    end else begin
                        prev_stall = 1'b1;
                        prev_re    = out_re;
                        prev_im    = out_im;
                    end
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_mul_valid"}, mul_valid, 0);
        check({tag, "_mul_a"}, {mul_a_re, mul_a_im}, 0);
        check({tag, "_mul_b"}, {mul_b_re, mul_b_im}, 0);
        check({tag, "_mul_w"}, {mul_w_re, mul_w_im}, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, {out_re, out_im}, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // kind: 0 impulse, 1 DC, 2 shifted impulse, 3 random.
    // Entry/exit point: just after a rising edge.
    task automatic run_frame(input int kind, input bit gaps, input bit bp_mode,
                             input bit abort);
        int n, n_mul, guard, hold, start;
        bit gap;
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0: begin x_re[i] = (i == 0) ? 65536 : 0; x_im[i] = 0; end
                1: begin x_re[i] = 65536; x_im[i] = 0; end
                2: begin x_re[i] = (i == 1) ? 65536 : 0; x_im[i] = 0; end
                default: begin
                    x_re[i] = int'($urandom_range(0, 524287)) - 262144;
                    x_im[i] = int'($urandom_range(0, 524287)) - 262144;
                end
            endcase
        end
        compute_model();
        frame_armed = 1'b1;

        n = 0;
        while (n < 16) begin
            gap      = gaps && ($urandom_range(0, 3) == 0);
            in_valid = !gap;
            in_re    = gap ? $urandom : x_re[n];
            in_im    = gap ? $urandom : x_im[n];
            @(posedge clk); #1;
            if (!gap) n++;
        end
        in_valid = 1'b0;

        n_mul = 0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            check($sformatf("mul_valid_c%0d", c), mul_valid, ((c - 1) % 9) < 8);
            check($sformatf("calc_out_valid_c%0d", c), out_valid, 0);
            check($sformatf("calc_in_ready_c%0d", c), in_ready, 0);
            check($sformatf("calc_busy_c%0d", c), busy, 1);
            if (mul_valid) n_mul++;
            if (abort && c == 23) begin
                #1;
                rst         = 1'b1;
                in_valid    = 1'b0;
                frame_armed = 1'b0;
                acc_idx     = 0;
                @(negedge clk);
                check_reset_values("abort");
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_re    = $urandom;
            in_im    = $urandom;
        end
        in_valid = 1'b0;
        check("mul_valid_total", n_mul, 32);

        @(negedge clk);
        check("latency_out_valid", out_valid, 1);

        start = frames_done;
        guard = 0;
        hold  = 0;
        while (frames_done == start && guard < 400) begin
            @(posedge clk); #1;
            guard++;
            if (bp_mode) begin
                if (acc_idx == 3 && hold < 5) begin out_ready = 1'b0; hold++; end
                else out_ready = 1'b1;
            end else out_ready = ($urandom_range(0, 3) != 0);
        end
        check("frame_completed", frames_done - start, 1);
        if (bp_mode) check("backpressure_cycles", hold, 5);
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Impulse: flat spectrum, exact.
        run_frame(0, 1'b0, 1'b0, 1'b0);
        check("model_imp_X7_re", exp_re[7], 65536);
        check("model_imp_X7_im", exp_im[7], 0);
        for (int kk = 0; kk < 16; kk += 5)
            check($sformatf("imp_X%0d", kk), {got_re[kk], got_im[kk]}, {32'd65536, 32'd0});

        // DC.
        run_frame(1, 1'b1, 1'b0, 1'b0);
        check("model_dc_X0_re", exp_re[0], 1048576);
        check_tol("dc_X0_re", got_re[0], 1048576, 2);
        check_tol("dc_X0_im", got_im[0], 0, 2);
        check_tol("dc_X9_re", got_re[9], 0, 2);
        check_tol("dc_X15_im", got_im[15], 0, 2);

        // Shifted impulse: X[k] = W16^k.
        run_frame(2, 1'b0, 1'b0, 1'b0);
        check_tol("model_sh_X2_re", exp_re[2], 46341, 2);
        check_tol("sh_X2_re", got_re[2], 46341, 2);
        check_tol("sh_X2_im", got_im[2], -46341, 2);
        check_tol("sh_X4_re", got_re[4], 0, 2);
        check_tol("sh_X4_im", got_im[4], -65536, 2);
        check_tol("sh_X8_re", got_re[8], -65536, 2);
        check_tol("sh_X8_im", got_im[8], 0, 2);

        // Random frame with 5-cycle backpressure at X[3].
        run_frame(3, 1'b0, 1'b1, 1'b0);

        // Random frames with load gaps and random out_ready.
        for (int f = 0; f < 4; f++) run_frame(3, 1'b1, 1'b0, 1'b0);

        // Reset at stage 2, butterfly 4, then a clean DC frame.
        run_frame(1, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("post_abort_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        run_frame(1, 1'b0, 1'b0, 1'b0);
        check_tol("post_abort_dc_X0_re", got_re[0], 1048576, 2);
        check_tol("post_abort_dc_X0_im", got_im[0], 0, 2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
